// File: rtl/vending_pkg.sv
// Shared definitions for the dispense sequencer: FSM states, request entry
// layout and helpers that map an entry onto the action to serve next.
package vending_pkg;

  localparam int ENTRY_W  = 3;
  localparam int P1_BIT   = 0;
  localparam int P2_BIT   = 1;
  localparam int COIN_BIT = 2;
  localparam int PULSE_W  = 4;
  localparam int WAIT_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    MOTOR1_ON,
    MOTOR2_ON,
    MOTOR_WAIT,
    COIN_ON,
    COIN_WAIT,
    FAULT
  } state_t;

  // Service order is product1, product2, then quarter; IDLE when nothing is left.
  function automatic state_t first_action(input logic [ENTRY_W-1:0] bits);
    state_t s;
    if (bits[P1_BIT])        s = MOTOR1_ON;
    else if (bits[P2_BIT])   s = MOTOR2_ON;
    else if (bits[COIN_BIT]) s = COIN_ON;
    else                     s = IDLE;
    return s;
  endfunction

  function automatic logic [ENTRY_W-1:0] action_mask(input state_t s);
    logic [ENTRY_W-1:0] m;
    m = '0;
    case (s)
      MOTOR1_ON: m[P1_BIT]   = 1'b1;
      MOTOR2_ON: m[P2_BIT]   = 1'b1;
      COIN_ON:   m[COIN_BIT] = 1'b1;
      default:   m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dispense_fifo.sv
// Request queue for the dispense sequencer; a pop frees a slot for a push in
// the same cycle, so a full queue still accepts when it is being drained.
module dispense_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign data    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: emptiness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dispense_sequencer.sv
// Serialises vend/coin-return requests onto the actuators: one actuator at a
// time, fixed-length pulses, then a bounded wait for the matching sensor.
module dispense_sequencer
  import vending_pkg::*;
#(
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int DEPTH          = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic product1,
  input  logic product2,
  input  logic quarter_out,
  input  logic vend_done,
  input  logic coin_done,
  output logic motor1,
  output logic motor2,
  output logic coin_eject,
  output logic busy,
  output logic queue_full,
  output logic overflow,
  output logic fault
);

  localparam logic [PULSE_W-1:0] PULSE_LOAD = PULSE_W'(PULSE_CYCLES - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LOAD  = WAIT_W'(TIMEOUT_CYCLES);

  state_t               state;
  state_t               state_next;
  state_t               launch_state;
  logic [ENTRY_W-1:0]   work;
  logic [ENTRY_W-1:0]   work_next;
  logic [ENTRY_W-1:0]   launch_bits;
  logic [ENTRY_W-1:0]   req;
  logic [ENTRY_W-1:0]   fifo_data;
  logic [PULSE_W-1:0]   pulse_cnt;
  logic [PULSE_W-1:0]   pulse_next;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [WAIT_W-1:0]    wait_next;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 sensor;

  assign req    = {quarter_out, product2, product1};
  assign push   = |req;
  assign pop    = (state == IDLE) && !fifo_empty;
  assign sensor = (state == COIN_WAIT) ? coin_done : vend_done;

  dispense_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (req),
    .data  (fifo_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      work       <= '0;
      pulse_cnt  <= '0;
      wait_cnt   <= '0;
      motor1     <= 1'b0;
      motor2     <= 1'b0;
      coin_eject <= 1'b0;
      overflow   <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_next;
      work       <= work_next;
      pulse_cnt  <= pulse_next;
      wait_cnt   <= wait_next;
      motor1     <= (state_next == MOTOR1_ON);
      motor2     <= (state_next == MOTOR2_ON);
      coin_eject <= (state_next == COIN_ON);
      overflow   <= overflow | (push & fifo_full & ~pop);
      fault      <= fault | (state_next == FAULT);
    end
  end

  // A new action launches either from a freshly popped entry or from whatever
  // remains of the working entry once a sensor confirms the previous one.
  always_comb begin
    launch_bits  = (state == IDLE) ? fifo_data : work;
    launch_state = first_action(launch_bits);
    state_next   = state;
    work_next    = work;
    pulse_next   = pulse_cnt;
    wait_next    = wait_cnt;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = launch_state;
          work_next  = launch_bits & ~action_mask(launch_state);
          pulse_next = PULSE_LOAD;
        end
      end
      MOTOR1_ON, MOTOR2_ON, COIN_ON: begin
        if (pulse_cnt == '0) begin
          state_next = (state == COIN_ON) ? COIN_WAIT : MOTOR_WAIT;
          wait_next  = WAIT_LOAD;
        end else begin
          pulse_next = pulse_cnt - 1'b1;
        end
      end
      MOTOR_WAIT, COIN_WAIT: begin
        // A sensor arriving on the last counted cycle still wins over the timeout.
        if (sensor) begin
          state_next = launch_state;
          work_next  = launch_bits & ~action_mask(launch_state);
          pulse_next = PULSE_LOAD;
        end else if (wait_cnt == WAIT_W'(1)) begin
          state_next = FAULT;
          wait_next  = '0;
        end else begin
          wait_next = wait_cnt - 1'b1;
        end
      end
      FAULT:   state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  assign busy       = (state != IDLE) || !fifo_empty;
  assign queue_full = fifo_full;

endmodule

// File: tb/tb_dispense_sequencer.sv
// Directed bench for dispense_sequencer with a timestamp-based reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_dispense_sequencer;

  localparam int P = 4;
  localparam int T = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic product1 = 1'b0, product2 = 1'b0, quarter_out = 1'b0;
  logic vend_done = 1'b0, coin_done = 1'b0;
  logic motor1, motor2, coin_eject, busy, queue_full, overflow, fault;

  int n_vectors = 0;
  int n_miscompares = 0;

  always #5 clk = ~clk;

  dispense_sequencer #(
    .PULSE_CYCLES   (P),
    .TIMEOUT_CYCLES (T),
    .DEPTH          (D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .product1    (product1),
    .product2    (product2),
    .quarter_out (quarter_out),
    .vend_done   (vend_done),
    .coin_done   (coin_done),
    .motor1      (motor1),
    .motor2      (motor2),
    .coin_eject  (coin_eject),
    .busy        (busy),
    .queue_full  (queue_full),
    .overflow    (overflow),
    .fault       (fault)
  );

  // Reference model: pending requests, the action in service and the cycle its
  // actuator rose; pulse and wait window follow from that timestamp.
  int  mcyc = 0;
  int  mq[$];
  int  pend[$];
  int  cur = -1;
  int  start = 0;
  bit  mfault = 1'b0;
  bit  movf = 1'b0;
  bit  model_valid = 1'b0;
  logic e_m1, e_m2, e_coin, e_busy, e_full, e_ovf, e_fault;

  always @(posedge clk) begin
    bit popping;
    int e;
    if (reset) begin
      mq.delete();
      pend.delete();
      cur    = -1;
      start  = 0;
      mfault = 1'b0;
      movf   = 1'b0;
    end else begin
      popping = !mfault && (cur < 0) && (mq.size() > 0);
      if (cur >= 0 && mcyc >= start + P && mcyc < start + P + T) begin
        if ((cur == 2) ? coin_done : vend_done) begin
          if (pend.size() > 0) begin
            cur   = pend.pop_front();
            start = mcyc + 1;
          end else begin
            cur = -1;
          end
        end else if (mcyc == start + P + T - 1) begin
          mfault = 1'b1;
          cur    = -1;
          pend.delete();
        end
      end
      if (popping) begin
        e = mq.pop_front();
        pend.delete();
        for (int b = 0; b < 3; b++) if (e[b]) pend.push_back(b);
        cur   = pend.pop_front();
        start = mcyc + 1;
      end
      if (product1 || product2 || quarter_out) begin
        if (mq.size() < D) mq.push_back(int'({quarter_out, product2, product1}));
        else movf = 1'b1;
      end
    end
    mcyc++;
    e_m1   = (cur == 0) && (mcyc - start < P);
    e_m2   = (cur == 1) && (mcyc - start < P);
    e_coin = (cur == 2) && (mcyc - start < P);
    e_busy = mfault || (cur >= 0) || (mq.size() > 0);
    e_full = (mq.size() == D);
    e_ovf  = movf;
    e_fault = mfault;
    model_valid = 1'b1;
  end

  task automatic checkOutput(input string name, input logic act, input logic exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Every cycle the DUT must agree with the model and keep actuators exclusive.
  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("motor1", motor1, e_m1);
      checkOutput("motor2", motor2, e_m2);
      checkOutput("coin_eject", coin_eject, e_coin);
      checkOutput("busy", busy, e_busy);
      checkOutput("queue_full", queue_full, e_full);
      checkOutput("overflow", overflow, e_ovf);
      checkOutput("fault", fault, e_fault);
      checkOutput("exclusive", ($countones({motor1, motor2, coin_eject}) <= 1), 1'b1);
    end
  end

  task automatic applyStimulus(input logic p1, input logic p2, input logic q,
                               input logic vd, input logic cd, input logic rst);
    @(negedge clk);
    product1    = p1;
    product2    = p2;
    quarter_out = q;
    vend_done   = vd;
    coin_done   = cd;
    reset       = rst;
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int vends;
    logic prev_m1;
    logic any_act;

    doReset();
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_fault", fault, 1'b0);
    checkOutput("rst_motor1", motor1, 1'b0);

    // Single product1 vend: request at k0, motor1 k2..k5, sensor at k8.
    $display("[TB] scenario: single vend");
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(0, 0, 0, (k == 8), 0, 0);
      case (k)
        1: begin checkOutput("s1_m1_k1", motor1, 1'b0); checkOutput("s1_busy_k1", busy, 1'b1); end
        2: checkOutput("s1_m1_k2", motor1, 1'b1);
        5: checkOutput("s1_m1_k5", motor1, 1'b1);
        6: checkOutput("s1_m1_k6", motor1, 1'b0);
        8: checkOutput("s1_busy_k8", busy, 1'b1);
        9: checkOutput("s1_busy_k9", busy, 1'b0);
        default: ;
      endcase
    end

    // Product1 plus quarter in one request: motor1 then coin_eject.
    $display("[TB] scenario: vend then coin");
    applyStimulus(1, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(0, 0, 0, (k == 7), (k == 13), 0);
      case (k)
        5:  checkOutput("s2_m1_k5", motor1, 1'b1);
        7:  begin checkOutput("s2_m1_k7", motor1, 1'b0); checkOutput("s2_coin_k7", coin_eject, 1'b0); end
        8:  checkOutput("s2_coin_k8", coin_eject, 1'b1);
        11: checkOutput("s2_coin_k11", coin_eject, 1'b1);
        12: checkOutput("s2_coin_k12", coin_eject, 1'b0);
        14: checkOutput("s2_busy_k14", busy, 1'b0);
        default: ;
      endcase
    end

    // Both products; vend_done on the last cycle of the first wait window.
    $display("[TB] scenario: sensor on final wait cycle");
    applyStimulus(1, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 22; k++) begin
      applyStimulus(0, 0, 0, (k == 13 || k == 20), 0, 0);
      case (k)
        13: begin checkOutput("s5_fault_k13", fault, 1'b0); checkOutput("s5_m2_k13", motor2, 1'b0); end
        14: begin checkOutput("s5_fault_k14", fault, 1'b0); checkOutput("s5_m2_k14", motor2, 1'b1); end
        17: checkOutput("s5_m2_k17", motor2, 1'b1);
        18: checkOutput("s5_m2_k18", motor2, 1'b0);
        21: begin checkOutput("s5_busy_k21", busy, 1'b0); checkOutput("s5_fault_k21", fault, 1'b0); end
        default: ;
      endcase
    end

    // Six back-to-back requests with a depth-4 queue: one is dropped.
    $display("[TB] scenario: queue overflow");
    vends = 0;
    prev_m1 = motor1;
    for (int k = 0; k <= 5; k++) begin
      applyStimulus(1, 0, 0, 0, 0, 0);
      if (motor1 && !prev_m1) vends++;
      prev_m1 = motor1;
    end
    checkOutput("s4_full_k5", queue_full, 1'b1);
    checkOutput("s4_ovf_k5", overflow, 1'b0);
    for (int k = 6; k <= 9; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      if (motor1 && !prev_m1) vends++;
      prev_m1 = motor1;
    end
    checkOutput("s4_ovf_k9", overflow, 1'b1);
    checkOutput("s4_full_k9", queue_full, 1'b1);
    for (int k = 0; k < 80; k++) begin
      applyStimulus(0, 0, 0, 1, 0, 0);
      if (motor1 && !prev_m1) vends++;
      prev_m1 = motor1;
    end
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      if (motor1 && !prev_m1) vends++;
      prev_m1 = motor1;
    end
    n_vectors++;
    if (vends != 5) begin
      n_miscompares++;
      $display("[TB] FAIL s4_vend_count: got %0d expected 5", vends);
    end
    checkOutput("s4_busy_end", busy, 1'b0);
    checkOutput("s4_ovf_end", overflow, 1'b1);
    doReset();
    checkOutput("s4_ovf_cleared", overflow, 1'b0);

    // Reset during the second cycle of a motor2 pulse, with a request present.
    $display("[TB] scenario: reset mid-pulse");
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("s6_m2_k2", motor2, 1'b1);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("s6_m2_k3", motor2, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("s6_m2_k4", motor2, 1'b0);
    checkOutput("s6_busy_k4", busy, 1'b0);
    checkOutput("s6_full_k4", queue_full, 1'b0);
    any_act = 1'b0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 0, 0, 1, 1, 0);
      any_act = any_act | motor1 | motor2 | coin_eject;
    end
    checkOutput("s6_no_actuation", any_act, 1'b0);

    // vend_done never arrives: fault 8 cycles after motor1 falls, and sticky.
    $display("[TB] scenario: sensor timeout");
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(0, (k == 15), (k == 16), 0, 0, 0);
      case (k)
        5:  checkOutput("s3_m1_k5", motor1, 1'b1);
        6:  begin checkOutput("s3_m1_k6", motor1, 1'b0); checkOutput("s3_fault_k6", fault, 1'b0); end
        13: checkOutput("s3_fault_k13", fault, 1'b0);
        14: begin
          checkOutput("s3_fault_k14", fault, 1'b1);
          checkOutput("s3_m1_k14", motor1, 1'b0);
          checkOutput("s3_m2_k14", motor2, 1'b0);
          checkOutput("s3_coin_k14", coin_eject, 1'b0);
        end
        default: ;
      endcase
    end
    for (int k = 0; k < 100; k++) applyStimulus(0, 0, 0, 1, 1, 0);
    checkOutput("s3_fault_late", fault, 1'b1);
    checkOutput("s3_m2_late", motor2, 1'b0);
    checkOutput("s3_coin_late", coin_eject, 1'b0);
    checkOutput("s3_busy_late", busy, 1'b1);

    doReset();
    checkOutput("final_fault_cleared", fault, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
